if_fetch_unit: RTL and testbench

Instruction-fetch stage for the 32-bit pipelined RISC-V core. Owns the program counter, issues instruction-memory requests over a valid/ready request channel, and writes `cpu_pkg::if_id_data_t` records (`pc_address`, `instruc`) toward decode, where they are consumed by the IF/ID pipeline register. Supports decode back-pressure through a one-entry skid buffer, and PC redirects from branch/jump resolution with discard of in-flight fetches.

---
 rtl/if_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RISC-V fetch stage. Owns the PC, one outstanding imem request,
// output register plus one-entry skid buffer, redirect with in-flight discard.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_bubbles).

package cpu_pkg;
   typedef struct packed {
      logic [31:0] pc_address;
      logic [31:0] instruc;
   } if_id_data_t;
endpackage

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [31:0]          imem_req_addr,
   input  logic                 imem_rsp_valid,
   input  logic [31:0]          imem_rsp_data,
   input  logic                 stall,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic                 if_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_bubbles,
`endif
   output cpu_pkg::if_id_data_t data_out
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT} state_e;

   state_e               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [31:0]          req_pc_q, req_pc_d;
   logic                 req_valid_q, req_valid_d;
   logic                 out_valid_q, out_valid_d;
   cpu_pkg::if_id_data_t out_q, out_d;
   cpu_pkg::if_id_data_t skid_q, skid_d;
   logic                 skid_full_q, skid_full_d;
   logic                 drop_q, drop_d;

   logic                 handshake;
   logic                 rsp_in_wait;
   logic                 deliver;
   logic                 consume;
   cpu_pkg::if_id_data_t rsp_entry;

   // req_valid_q is only ever set while the FSM sits in REQ.
   assign handshake   = req_valid_q && imem_req_ready;
   assign rsp_in_wait = (state_q == WAIT) && imem_rsp_valid;
   assign deliver     = rsp_in_wait && !drop_q && !redirect_valid;
   assign consume     = out_valid_q && !stall;
   assign rsp_entry   = {req_pc_q, imem_rsp_data};

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      skid_d      = skid_q;
      skid_full_d = skid_full_q;
      drop_d      = drop_q;

      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (handshake) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) state_d = REQ;
         end
         default: state_d = BOOT;
      endcase

      if (rsp_in_wait && drop_q) drop_d = 1'b0;

      if (consume) begin
         if (skid_full_q) begin
            out_d       = skid_q;
            skid_full_d = deliver;
            if (deliver) skid_d = rsp_entry;
         end else if (deliver) begin
            out_d = rsp_entry;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (deliver) begin
         if (!out_valid_q && !skid_full_q) begin
            out_d       = rsp_entry;
            out_valid_d = 1'b1;
         end else begin
            skid_d      = rsp_entry;
            skid_full_d = 1'b1;
         end
      end

      // A response arriving alongside the redirect is consumed here, so only a
      // still-pending or just-issued request needs the drop marker.
      if (redirect_valid) begin
         pc_d        = {redirect_pc[31:2], 2'b00};
         out_valid_d = 1'b0;
         skid_full_d = 1'b0;
         if (handshake || ((state_q == WAIT) && !imem_rsp_valid)) drop_d = 1'b1;
      end

      req_valid_d = (state_d == REQ) && !skid_full_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the payload registers are reset too, because data_out must read zero out of reset.
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         req_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
         skid_full_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values computed above.
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         skid_full_q <= skid_full_d;
         drop_q      <= drop_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = pc_q;
   assign if_valid       = out_valid_q;
   assign data_out       = out_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] bubbles_q, bubbles_d;

   // Saturating counters, deliberately blind to redirects.
   always_comb begin
      fetched_d = fetched_q;
      bubbles_d = bubbles_q;
      if (consume && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
      if (!out_valid_q && !stall && (bubbles_q != '1)) bubbles_d = bubbles_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetched_q <= '0;
         bubbles_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         bubbles_q <= bubbles_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory responder model, scoreboard of
// expected {pc, instr} records popped whenever decode consumes an entry.

module tb_if_fetch_unit;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   if_id_data_t data_out;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          mem_lat = 1;
   int          hs_count = 0;
   logic [31:0] last_hs_addr = 32'h1;
   bit          mon_en = 1'b1;
   if_id_data_t exp_q[$];

   always #5 clock = ~clock;

   if_fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .data_out       (data_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!if_valid && (n < max));
      check(tag, 64'(if_valid), 64'd1);
   endtask

   task automatic wait_drain(input int max, input string tag);
      int n = 0;
      while ((exp_q.size() != 0) && (n < max)) begin
         @(negedge clock);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // Wait (at posedge+1) until the responder has seen a handshake for addr.
   task automatic wait_hs_addr(input logic [31:0] addr, input int max, input string tag);
      int n = 0;
      while ((last_hs_addr != addr) && (n < max)) begin
         @(posedge clock);
         #1;
         n++;
      end
      check(tag, 64'(last_hs_addr), 64'(addr));
   endtask

   // Memory: returns addr + 0x100, mem_lat cycles after the handshake edge.
   initial begin : mem_model
      logic [31:0] a;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clock);
         if (reset && imem_req_valid && imem_req_ready) begin
            a            = imem_req_addr;
            last_hs_addr = a;
            hs_count++;
            repeat (mem_lat) @(posedge clock);
            #1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = a + 32'h100;
            @(posedge clock);
            #1;
            imem_rsp_valid = 1'b0;
         end
      end
   end

   always @(negedge clock) begin : monitor
      if_id_data_t e;
      if (mon_en && reset && if_valid && !stall) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_output", 64'(if_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", data_out, e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      for (int i = 0; i < 6; i++) exp_q.push_back({32'(4 * i), 32'(4 * i + 32'h100)});

      // Reset
      @(negedge clock);
      check("rst_if_valid", 64'(if_valid), 64'd0);
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_data_out", data_out, 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("boot_req_valid", 64'(imem_req_valid), 64'd0);
      @(negedge clock);
      check("first_req_valid", 64'(imem_req_valid), 64'd1);
      check("first_req_addr", 64'(imem_req_addr), 64'h0);

      // Straight-line fetch: 0x0, 0x4, 0x8 with one bubble between them
      for (int k = 0; k < 3; k++) begin
         wait_valid(8, "a_valid");
         if (k < 2) begin
            @(negedge clock);
            check("a_bubble", 64'(if_valid), 64'd0);
         end
      end

      // Stall: output holds 0xC, skid takes 0x10, no request for 0x14
      @(posedge clock);
      #1 stall = 1'b1;
      wait_valid(8, "b_valid");
      check("b_first_data", data_out, {32'hC, 32'h10C});
      repeat (6) begin
         @(negedge clock);
         check("b_hold_valid", 64'(if_valid), 64'd1);
         check("b_hold_data", data_out, {32'hC, 32'h10C});
      end
      check("b_no_req", 64'(imem_req_valid), 64'd0);
      check("b_pc_parked", 64'(imem_req_addr), 64'h14);
      @(posedge clock);
      #1;
      stall   = 1'b0;
      mem_lat = 2;

      // Redirect while the fetch of 0x18 is outstanding
      wait_hs_addr(32'h18, 40, "c_hs_18");
      check("b_drain", 64'(exp_q.size()), 64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      stall          = 1'b1;
      @(posedge clock);
      #1 redirect_valid = 1'b0;
      @(negedge clock);
      check("c_redirect_addr", 64'(imem_req_addr), 64'h200);
      check("c_if_valid_low", 64'(if_valid), 64'd0);
      check("c_wait_no_req", 64'(imem_req_valid), 64'd0);
      wait_valid(20, "c_valid");
      check("c_target_data", data_out, {32'h200, 32'h300});
      repeat (8) begin
         @(negedge clock);
         check("c_hold_data", data_out, {32'h200, 32'h300});
      end
      check("c_skid_full_no_req", 64'(imem_req_valid), 64'd0);
      check("c_pc_parked", 64'(imem_req_addr), 64'h208);

      // Redirect with stall and a full skid, target at the top of memory
      @(posedge clock);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(posedge clock);
      #1 redirect_valid = 1'b0;
      @(negedge clock);
      check("d_flush_valid", 64'(if_valid), 64'd0);
      check("d_req_valid", 64'(imem_req_valid), 64'd1);
      check("d_req_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
      wait_valid(20, "d_valid");
      check("d_target_data", data_out, {32'hFFFF_FFFC, 32'h0000_00FC});
      check("e_wrap_req_valid", 64'(imem_req_valid), 64'd1);
      check("e_wrap_addr", 64'(imem_req_addr), 64'h0);
      exp_q.push_back({32'hFFFF_FFFC, 32'h0000_00FC});
      exp_q.push_back({32'h0, 32'h100});
      exp_q.push_back({32'h4, 32'h104});
      @(posedge clock);
      #1 stall = 1'b0;
      wait_drain(40, "e_drain");

      // Reset asserted mid-WAIT: stale response ignored, restart at 0x0
      @(posedge clock);
      #1;
      mon_en = 1'b0;
      snap   = hs_count;
      begin
         int n = 0;
         while ((hs_count == snap) && (n < 40)) begin
            @(posedge clock);
            #1;
            n++;
         end
         check("f_hs_seen", 64'(hs_count != snap), 64'd1);
      end
      reset = 1'b0;
      @(negedge clock);
      check("f_rst_if_valid", 64'(if_valid), 64'd0);
      check("f_rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("f_rst_data_out", data_out, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      exp_q.delete();
      exp_q.push_back({32'h0, 32'h100});
      mon_en = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("f_restart_req_valid", 64'(imem_req_valid), 64'd1);
      check("f_restart_addr", 64'(imem_req_addr), 64'h0);
      check("f_stale_ignored", 64'(if_valid), 64'd0);
      wait_drain(30, "f_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
